exp_alu_arbiter: RTL and testbench

- Shares one W-bit exponent add/subtract datapath (ripple adder, sub via b XOR sub with cin=sub, cout = carry XOR sub) between NREQ requesters inside the FPU, e.g. the FP adder's exponent-difference stage and the FP multiplier's exponent-sum stage.
- Round-robin arbitration, valid/ready handshakes on the request and response sides, and sequencing of a single registered operation at a time.
- The datapath is instantiated outside this block. It is driven from registered operands and its result is captured here.

---
 rtl/exp_alu_arbiter.sv | 117 +++++++++++
 tb/tb_exp_alu_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_alu_arbiter.sv
// Round-robin arbiter sequencing one registered exponent add/sub at a time
// through an external shared datapath, with valid/ready on both sides.
module exp_alu_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic [W-1:0]      dp_a,
  output logic [W-1:0]      dp_b,
  output logic              dp_sub,
  input  logic [W-1:0]      dp_sum,
  input  logic              dp_cout,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rr_ptr, owner;
  logic [PW-1:0] grant_idx, rr_nxt;
  logic          grant_found;
  logic          capture_req, capture_rsp, release_rsp;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      logic [PW-1:0] idx;
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
    rr_nxt = PW'((int'(grant_idx) + 1) % NREQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    capture_req = 1'b0;
    capture_rsp = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so req_ready reads 0 while reset is held.
        if (grant_found && rst_n) begin
          req_ready[grant_idx] = 1'b1;
          capture_req          = 1'b1;
          state_nxt            = EXEC;
        end
      end
      EXEC: begin
        capture_rsp = 1'b1;
        state_nxt   = RESP;
      end
      RESP: begin
        if (rsp_ready[owner]) begin
          release_rsp = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Operand/result registers; dp_* keep their last values between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_a      <= '0;
      dp_b      <= '0;
      dp_sub    <= 1'b0;
      owner     <= '0;
      rr_ptr    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_valid <= '0;
    end else begin
      if (capture_req) begin
        dp_a   <= req_a[grant_idx*W +: W];
        dp_b   <= req_b[grant_idx*W +: W];
        dp_sub <= req_sub[grant_idx];
        owner  <= grant_idx;
        rr_ptr <= rr_nxt;
      end
      if (capture_rsp) begin
        rsp_sum   <= dp_sum;
        rsp_cout  <= dp_cout;
        rsp_valid <= NREQ'(1) << owner;
      end
      if (release_rsp) rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_exp_alu_arbiter.sv
// Bench for exp_alu_arbiter: directed cases plus randomized traffic against
// an arithmetic/round-robin reference model; includes a model of the datapath.
module tb_exp_alu_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 5;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic [W-1:0]      dp_a;
  logic [W-1:0]      dp_b;
  logic              dp_sub;
  logic [W-1:0]      dp_sum;
  logic              dp_cout;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int rr_model = 0;
  logic [W-1:0] op_a [NREQ];
  logic [W-1:0] op_b [NREQ];
  logic         op_sub [NREQ];

  exp_alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub),
    .dp_sum(dp_sum), .dp_cout(dp_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  // External shared datapath: b XOR sub, cin = sub, cout = carry XOR sub.
  logic [W:0] dp_raw;
  always_comb dp_raw = {1'b0, dp_a} + {1'b0, dp_b ^ {W{dp_sub}}} + (W+1)'(dp_sub);
  assign dp_sum  = dp_raw[W-1:0];
  assign dp_cout = dp_raw[W] ^ dp_sub;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic s);
    req_valid[i]     = v;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_sub[i]       = s;
    op_a[i]          = a;
    op_b[i]          = b;
    op_sub[i]        = s;
  endtask

  // Winner = valid requester with the smallest forward distance from rr_model.
  function automatic int model_winner();
    int best = -1;
    int bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      int d = (i - rr_model + NREQ) % NREQ;
      if (req_valid[i] && d < bestd) begin
        best = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] one = 1;
    return (w < 0) ? '0 : (one << w);
  endfunction

  // One complete transaction from an IDLE cycle back to the next IDLE cycle.
  task automatic run_op(input int hold, input bit wrong_ready, input bit keep_valid,
                        input int exp_win);
    int w;
    int ai, bi, full;
    logic [W-1:0] ex_sum;
    logic         ex_cout;
    #1;
    w = (exp_win >= 0) ? exp_win : model_winner();
    check("grant", req_ready, onehot(w));
    check("idle_busy", busy, 0);
    ai = op_a[w];
    bi = op_b[w];
    if (op_sub[w]) begin
      ex_sum  = W'((ai - bi + (1 << W)) % (1 << W));
      ex_cout = (ai < bi);
    end else begin
      full    = ai + bi;
      ex_sum  = W'(full % (1 << W));
      ex_cout = (full >= (1 << W));
    end
    tick();
    rr_model = (w + 1) % NREQ;
    if (!keep_valid) req_valid[w] = 1'b0;
    #1;
    check("exec_ready", req_ready, 0);
    check("exec_busy", busy, 1);
    check("exec_rsp_valid", rsp_valid, 0);
    check("dp_a", dp_a, ai);
    check("dp_b", dp_b, bi);
    check("dp_sub", dp_sub, op_sub[w]);
    tick();
    check("rsp_valid", rsp_valid, onehot(w));
    check("rsp_sum", rsp_sum, ex_sum);
    check("rsp_cout", rsp_cout, ex_cout);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = wrong_ready ? ~onehot(w) : '0;
      tick();
      check("hold_rsp_valid", rsp_valid, onehot(w));
      check("hold_rsp_sum", rsp_sum, ex_sum);
      check("hold_rsp_cout", rsp_cout, ex_cout);
      check("hold_ready", req_ready, 0);
      check("hold_busy", busy, 1);
    end
    rsp_ready = onehot(w);
    #1;
    check("accept_no_grant", req_ready, 0);
    tick();
    rsp_ready = '0;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_busy", busy, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rr_model = 0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_sub = '0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) drive_req(i, 1'b0, '0, '0, 1'b0);
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_dp_a", dp_a, 0);
    check("rst_dp_b", dp_b, 0);
    check("rst_dp_sub", dp_sub, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Basic add, carry-out add, borrow and no-borrow subtract.
    drive_req(0, 1'b1, 5'd9, 5'd4, 1'b0);
    run_op(0, 0, 0, 0);
    drive_req(0, 1'b1, 5'd31, 5'd1, 1'b0);
    run_op(0, 0, 0, 0);
    drive_req(0, 1'b1, 5'd3, 5'd7, 1'b1);
    run_op(0, 0, 0, 0);
    drive_req(0, 1'b1, 5'd7, 5'd3, 1'b1);
    run_op(0, 0, 0, 0);

    // Both requesters holding from reset: grants alternate.
    apply_reset();
    drive_req(0, 1'b1, 5'd20, 5'd15, 1'b0);
    drive_req(1, 1'b1, 5'd2, 5'd30, 1'b1);
    run_op(0, 0, 1, 0);
    run_op(0, 0, 1, 1);
    run_op(0, 0, 1, 0);
    run_op(0, 0, 1, 1);

    // Backpressure with wrong-bit rsp_ready while requester 1 waits.
    run_op(5, 1, 0, 0);
    run_op(0, 0, 0, 1);

    // Reset during EXEC after granting 0 (rr would otherwise point at 1).
    drive_req(0, 1'b1, 5'd11, 5'd12, 1'b0);
    drive_req(1, 1'b1, 5'd13, 5'd14, 1'b1);
    #1;
    check("pre_rst_grant", req_ready, 2'b01);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_dp_a", dp_a, 0);
    check("mid_rst_dp_b", dp_b, 0);
    check("mid_rst_rsp_sum", rsp_sum, 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    rr_model = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_no_rsp", rsp_valid, 0);
      check("post_rst_idle", busy, 0);
    end
    req_valid = 2'b11;
    run_op(0, 0, 0, 0);
    run_op(0, 0, 0, 1);

    // One-cycle pulse on req_valid[1] while busy is dropped without effect.
    drive_req(0, 1'b1, 5'd5, 5'd6, 1'b0);
    run_op(0, 0, 0, 0);
    drive_req(0, 1'b1, 5'd8, 5'd8, 1'b1);
    #1;
    check("pulse_grant0", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    drive_req(1, 1'b1, 5'd1, 5'd1, 1'b0);
    rr_model = 1;
    tick();
    req_valid[1] = 1'b0;
    check("pulse_rsp_owner", rsp_valid, 2'b01);
    check("pulse_rsp_sum", rsp_sum, 0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    for (int c = 0; c < 3; c++) begin
      check("pulse_no_grant", req_ready, 0);
      check("pulse_no_rsp", rsp_valid, 0);
      check("pulse_idle", busy, 0);
      tick();
    end

    // Randomized traffic: pending requesters keep their operands.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          drive_req(i, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      if (req_valid == '0) begin
        int r = $urandom_range(0, NREQ - 1);
        drive_req(r, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      end
      run_op($urandom_range(0, 3), 1'($urandom), 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
